gearbox_67_lock_ctrl: RTL

Word-lock controller for the 20-to-67 bit gearbox. It watches the sync header of each 67-bit word the gearbox emits, pulses a slip request back to the gearbox until header alignment is found, and declares word lock after a run of good headers. Once locked, it declares loss of lock when too many bad headers fall inside a sliding window. It sits directly beside the gearbox in the 64b/67b receive path, ahead of descrambling and framing.

---
 rtl/gearbox_67_pkg.sv | 17 +
 rtl/gearbox_lock_sat_cnt.sv | 17 +
 rtl/gearbox_67_lock_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gearbox_67_pkg.sv
// Shared types, header constants and header classification for the 64b/67b word-lock controller.
package gearbox_67_pkg;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP_HOLD = 2'd1,
    LOCKED    = 2'd2
  } lock_state_e;

  localparam logic [1:0] HDR_DATA = 2'b10;
  localparam logic [1:0] HDR_CTRL = 2'b01;

  function automatic logic hdr_good(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/gearbox_lock_sat_cnt.sv
// 16-bit saturating event counter with synchronous active-low clear.
module gearbox_lock_sat_cnt (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/gearbox_67_lock_ctrl.sv
// Word-lock controller for the 20-to-67 gearbox: slips until headers align, then tracks lock.
// Statistics counters are built only when GEARBOX_LOCK_STATS_EN is defined.
module gearbox_67_lock_ctrl
  import gearbox_67_pkg::*;
#(
  parameter int GOOD_TO_LOCK  = 64,
  parameter int BAD_TO_UNLOCK = 16,
  parameter int WINDOW        = 64,
  parameter int SLIP_WAIT     = 4
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic        din_valid,
  input  logic [2:0]  din_hdr,
  output logic        slip,
  output logic        word_lock,
  output logic        lock_lost,
  output logic [15:0] slip_count,
  output logic [15:0] bad_hdr_count
);

  localparam int GW = $clog2(GOOD_TO_LOCK) + 1;
  localparam int BW = $clog2(BAD_TO_UNLOCK) + 1;
  localparam int WW = $clog2(WINDOW) + 1;
  localparam int HW = $clog2(SLIP_WAIT) + 1;

  lock_state_e state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d, good_inc;
  logic [BW-1:0] bad_cnt_q, bad_cnt_d, bad_inc;
  logic [WW-1:0] win_cnt_q, win_cnt_d, win_inc;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  logic          slip_d, word_lock_d, lock_lost_d;
  logic          hdr_ok;

  // Bit 66 only flags payload inversion; lock decisions ignore it.
  logic unused_hdr_inv;
  assign unused_hdr_inv = din_hdr[2];

  assign hdr_ok   = hdr_good(din_hdr[1:0]);
  assign good_inc = good_cnt_q + GW'(1);
  assign bad_inc  = bad_cnt_q + BW'(1);
  assign win_inc  = win_cnt_q + WW'(1);
  assign hold_inc = hold_cnt_q + HW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q     <= HUNT;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      win_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      slip        <= 1'b0;
      word_lock   <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      win_cnt_q   <= win_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      slip        <= slip_d;
      word_lock   <= word_lock_d;
      lock_lost   <= lock_lost_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    win_cnt_d  = win_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (hdr_ok) begin
            if (good_inc == GW'(GOOD_TO_LOCK)) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
              win_cnt_d  = '0;
            end else begin
              good_cnt_d = good_inc;
            end
          end else begin
            state_d    = SLIP_HOLD;
            good_cnt_d = '0;
            hold_cnt_d = '0;
          end
        end
        SLIP_HOLD: begin
          if (hold_inc == HW'(SLIP_WAIT)) begin
            state_d    = HUNT;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_inc;
          end
        end
        LOCKED: begin
          // Unlock is checked before the window wrap so it wins on a shared word.
          if (!hdr_ok && (bad_inc == BW'(BAD_TO_UNLOCK))) begin
            state_d    = HUNT;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            win_cnt_d  = '0;
          end else if (win_inc == WW'(WINDOW)) begin
            win_cnt_d = '0;
            bad_cnt_d = '0;
          end else begin
            win_cnt_d = win_inc;
            if (!hdr_ok) bad_cnt_d = bad_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    slip_d      = 1'b0;
    lock_lost_d = 1'b0;
    word_lock_d = (state_d == LOCKED);
    if (din_valid) begin
      slip_d      = (state_q == HUNT) && !hdr_ok;
      lock_lost_d = (state_q == LOCKED) && (state_d == HUNT);
    end
  end

`ifdef GEARBOX_LOCK_STATS_EN
  logic bad_stat_inc;
  assign bad_stat_inc = din_valid && (state_q == LOCKED) && !hdr_ok;

  gearbox_lock_sat_cnt u_slip_cnt (
    .clk   (clk),
    .clr_n (srst_n),
    .inc   (slip_d),
    .count (slip_count)
  );

  gearbox_lock_sat_cnt u_bad_cnt (
    .clk   (clk),
    .clr_n (srst_n),
    .inc   (bad_stat_inc),
    .count (bad_hdr_count)
  );
`else
  assign slip_count    = '0;
  assign bad_hdr_count = '0;
`endif

endmodule
